// File: rtl/controlador_base_display_pkg.sv
// Shared base codes and FSM encoding for the ALU display path.
// The base converter decodes the same base_t values.
package controlador_base_display_pkg;

  typedef enum logic [1:0] {
    BASE_DEC = 2'b00,
    BASE_HEX = 2'b01,
    BASE_OCT = 2'b10
  } base_t;

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    EXIBINDO  = 2'b01,
    CONGELADO = 2'b10
  } estado_t;

  // 11 is unreachable: anything not DEC/HEX wraps back to DEC.
  function automatic base_t proxima_base(input base_t b);
    case (b)
      BASE_DEC: return BASE_HEX;
      BASE_HEX: return BASE_OCT;
      default:  return BASE_DEC;
    endcase
  endfunction

endpackage

// File: rtl/controlador_base_display_sincronizador_borda.sv
// Two-flop synchronizer plus rising-edge detector for debounced push buttons.
// o_borda is high for one cycle, two edges after the button is first sampled high.
module sincronizador_borda (
  input  logic clk,
  input  logic rst,
  input  logic i_botao,
  output logic o_borda
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_anterior;
  logic       r_armado;
  logic [1:0] r_pronto;

  // r_armado only sets once the chain has carried a real low sample, so a
  // button held through reset release never counts as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_anterior <= 1'b0;
      r_armado   <= 1'b0;
      r_pronto   <= 2'b00;
    end else begin
      r_sync1    <= i_botao;
      r_sync2    <= r_sync1;
      r_anterior <= r_sync2;
      r_pronto   <= {r_pronto[0], 1'b1};
      if (r_pronto[1] && !r_sync2) r_armado <= 1'b1;
    end
  end

  assign o_borda = r_sync2 & ~r_anterior & r_armado;

endmodule

// File: rtl/controlador_base_display.sv
// Holds the ALU result and numeric base shown on the display; button/timer step the base.
// Captures and base steps appear one cycle after the sampling edge, with a one-cycle atualizado pulse.
module controlador_base_display
  import controlador_base_display_pkg::*;
#(
  parameter int unsigned CICLOS_AUTO = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] resultado,
  input  logic       resultado_valido,
  input  logic       botao_base,
  input  logic       modo_auto,
  input  logic       congelar,
  output logic [7:0] valor_binario,
  output logic [1:0] base_selecionada,
  output logic       exibe_ativo,
  output logic       atualizado
);

  localparam int TW = $clog2(CICLOS_AUTO);
  localparam logic [TW-1:0] TERMINAL = TW'(CICLOS_AUTO - 1);

  estado_t       r_estado;
  estado_t       w_prox_estado;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_prox_timer;
  logic [7:0]    r_valor;
  base_t         r_base;
  logic          r_exibe;
  logic          r_atualizado;
  logic          w_borda;
  logic          w_captura;
  logic          w_botao;
  logic          w_expira;
  logic          w_passo;

  sincronizador_borda u_sinc_botao (
    .clk     (clk),
    .rst     (rst),
    .i_botao (botao_base),
    .o_borda (w_borda)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_estado <= OCIOSO;
    else     r_estado <= w_prox_estado;
  end

  always_comb begin
    w_prox_estado = r_estado;
    w_prox_timer  = r_timer;
    w_captura     = 1'b0;
    w_botao       = 1'b0;
    w_expira      = 1'b0;
    case (r_estado)
      OCIOSO: begin
        w_captura = resultado_valido;
        w_botao   = w_borda;
        if (resultado_valido) w_prox_estado = EXIBINDO;
      end
      EXIBINDO: begin
        w_captura = resultado_valido;
        w_botao   = w_borda;
        w_expira  = modo_auto && (r_timer == TERMINAL);
        if (congelar) w_prox_estado = CONGELADO;
      end
      CONGELADO: begin
        if (!congelar) w_prox_estado = EXIBINDO;
      end
      default: w_prox_estado = OCIOSO;
    endcase
    // Frozen: the timer keeps its count so auto cycling resumes where it left off.
    if (r_estado != CONGELADO) begin
      if (w_botao || !modo_auto || w_expira) w_prox_timer = '0;
      else if (r_estado == EXIBINDO)         w_prox_timer = r_timer + 1'b1;
    end
  end

  assign w_passo = w_botao | w_expira;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer      <= '0;
      r_valor      <= 8'h00;
      r_base       <= BASE_DEC;
      r_exibe      <= 1'b0;
      r_atualizado <= 1'b0;
    end else begin
      r_timer      <= w_prox_timer;
      if (w_captura) r_valor <= resultado;
      if (w_passo)   r_base  <= proxima_base(r_base);
      r_exibe      <= (w_prox_estado != OCIOSO);
      r_atualizado <= w_captura | w_passo;
    end
  end

  assign valor_binario    = r_valor;
  assign base_selecionada = r_base;
  assign exibe_ativo      = r_exibe;
  assign atualizado       = r_atualizado;

endmodule
